// File: rtl/core_sequencer.sv
// core_sequencer: autonomous instruction sequencer for the core.
// Fetches instructions from a synchronous ROM, presents each on `instruction`
// for its hold time with NOP cycles in between, and hands the core memory
// port to an external host loader on request.
// Optional feature: define CORE_SEQ_BREAKPOINT_EN to add a single PC
// breakpoint (break_pc / break_en inputs, sticky bp_hit output).
module core_sequencer #(
  parameter int                           INSTRUCTION_WIDTH = 15,
  parameter int                           PC_WIDTH          = 8,
  parameter logic [INSTRUCTION_WIDTH-1:0] NOP_INSTR         = 15'h42C0,
  parameter logic [INSTRUCTION_WIDTH-1:0] HALT_INSTR        = 15'h7FFF,
  parameter int                           MEM_HOLD          = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [PC_WIDTH-1:0]          entry_pc,
  input  logic                         halt_req,
  input  logic                         host_req,
  output logic                         host_gnt,
  output logic [PC_WIDTH-1:0]          imem_addr,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_rdata,
  output logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic [PC_WIDTH-1:0]          pc,
  output logic                         running,
`ifdef CORE_SEQ_BREAKPOINT_EN
  input  logic [PC_WIDTH-1:0]          break_pc,
  input  logic                         break_en,
  output logic                         bp_hit,
`endif
  output logic                         halted
);

  // Hold counter counts down the remaining ISSUE cycles after the first one,
  // so it only needs to represent MEM_HOLD-1.
  localparam int                HOLD_W    = (MEM_HOLD > 1) ? $clog2(MEM_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(MEM_HOLD - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_HOST   = 3'd4,
    ST_HALTED = 3'd5
  } state_t;

  state_t                         r_state;
  state_t                         r_retState;
  logic [PC_WIDTH-1:0]            r_pc;
  logic [INSTRUCTION_WIDTH-1:0]   r_instr;
  logic [HOLD_W-1:0]              r_hold;

  state_t                         w_nextState;
  state_t                         w_nextRetState;
  logic [PC_WIDTH-1:0]            w_nextPc;
  logic [INSTRUCTION_WIDTH-1:0]   w_nextInstr;
  logic [HOLD_W-1:0]              w_nextHold;
  logic                           w_isMem;

  // Load/store encodings: top bit clear and the next four bits equal to 0001.
  assign w_isMem = (imem_rdata[INSTRUCTION_WIDTH-1] == 1'b0) &&
                   (imem_rdata[INSTRUCTION_WIDTH-2 -: 4] == 4'b0001);

`ifdef CORE_SEQ_BREAKPOINT_EN
  logic r_bpHit;
  logic r_bpSkip;
  logic w_bpMatch;
  logic w_bpFire;
  logic w_startTaken;
  logic w_pcStep;

  // r_bpSkip suppresses the breakpoint at the address execution was just
  // (re)started from, until the pc moves on.
  assign w_bpMatch    = break_en && (r_pc == break_pc) && !r_bpSkip;
  assign w_bpFire     = (r_state == ST_FETCH) && !halt_req && w_bpMatch;
  assign w_startTaken = start && ((r_state == ST_IDLE) || (r_state == ST_HALTED));
  assign w_pcStep     = (r_state == ST_ISSUE) && (r_hold == '0);
  assign bp_hit       = r_bpHit;
`endif

  // Next-state, next-pc and next-instruction logic; the instruction register
  // holds NOP in every cycle that is not an ISSUE cycle.
  always_comb begin
    w_nextState    = r_state;
    w_nextRetState = r_retState;
    w_nextPc       = r_pc;
    w_nextInstr    = NOP_INSTR;
    w_nextHold     = '0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_nextState = ST_FETCH;
          w_nextPc    = entry_pc;
        end else if (host_req) begin
          w_nextState    = ST_HOST;
          w_nextRetState = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (halt_req) begin
          w_nextState = ST_HALTED;
        end
`ifdef CORE_SEQ_BREAKPOINT_EN
        else if (w_bpMatch) begin
          w_nextState = ST_HALTED;
        end
`endif
        else if (host_req) begin
          w_nextState    = ST_HOST;
          w_nextRetState = ST_FETCH;
        end else begin
          w_nextState = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rdata == HALT_INSTR) begin
          w_nextState = ST_HALTED;
        end else begin
          w_nextState = ST_ISSUE;
          w_nextInstr = imem_rdata;
          w_nextHold  = w_isMem ? HOLD_LOAD : '0;
        end
      end
      ST_ISSUE: begin
        if (r_hold == '0) begin
          w_nextState = ST_FETCH;
          w_nextPc    = r_pc + 1'b1;
        end else begin
          w_nextInstr = r_instr;
          w_nextHold  = r_hold - 1'b1;
        end
      end
      ST_HOST: begin
        if (!host_req) begin
          w_nextState = r_retState;
        end
      end
      ST_HALTED: begin
        if (start) begin
          w_nextState = ST_FETCH;
          w_nextPc    = entry_pc;
        end else if (host_req) begin
          w_nextState    = ST_HOST;
          w_nextRetState = ST_HALTED;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // State, pc, instruction and hold registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_retState <= ST_IDLE;
      r_pc       <= '0;
      r_instr    <= NOP_INSTR;
      r_hold     <= '0;
    end else begin
      r_state    <= w_nextState;
      r_retState <= w_nextRetState;
      r_pc       <= w_nextPc;
      r_instr    <= w_nextInstr;
      r_hold     <= w_nextHold;
    end
  end

`ifdef CORE_SEQ_BREAKPOINT_EN
  // Sticky breakpoint flag cleared by an accepted start, plus the re-arm guard.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bpHit  <= 1'b0;
      r_bpSkip <= 1'b0;
    end else begin
      if (w_startTaken) begin
        r_bpHit  <= 1'b0;
        r_bpSkip <= 1'b1;
      end else begin
        if (w_bpFire) begin
          r_bpHit <= 1'b1;
        end
        if (w_pcStep) begin
          r_bpSkip <= 1'b0;
        end
      end
    end
  end
`endif

  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign instruction = r_instr;
  assign host_gnt    = (r_state == ST_HOST);
  assign running     = (r_state == ST_FETCH) || (r_state == ST_WAIT) || (r_state == ST_ISSUE);
  assign halted      = (r_state == ST_HALTED);

endmodule
